// File: rtl/simon_blinker_if.sv
// simon_blinker_if: bundles the controller handshake and pattern memory read
// port of the Simon playback stage.
//   on_blinker   controller -> blinker, playback request (level)
//   level        controller -> blinker, entries to play
//   blinker_done blinker -> controller, one-cycle completion pulse
//   busy         blinker -> controller, high outside IDLE
//   mem_addr     blinker -> memory, read address
//   mem_data     memory -> blinker, colour code (one cycle after mem_addr)
// master: controller/memory side.  slave: the blinker.
interface simon_blinker_if #(
  parameter int ADDR_W = 4
);
  logic              on_blinker;
  logic [3:0]        level;
  logic              blinker_done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data;

  modport master (
    output on_blinker, level, mem_data,
    input  blinker_done, busy, mem_addr
  );

  modport slave (
    input  on_blinker, level, mem_data,
    output blinker_done, busy, mem_addr
  );
endinterface

// File: rtl/simon_blinker.sv
// simon_blinker: plays back the stored Simon colour sequence on the LEDs.
// While on_blinker is held, entries 0..len-1 are read from pattern memory and
// each is shown for ON_CYCLES followed by an OFF_CYCLES dark gap; then
// blinker_done pulses for one cycle.
// Ports:
//   clk    clock
//   reset  synchronous, active-low reset
//   bus    simon_blinker_if.slave (handshake + pattern memory read port)
//   leds   one-hot LED drive, 0 when dark
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for on_blinker; latches clamped length
// ADDR  | mem_addr = idx presented to synchronous memory
// LOAD  | mem_data valid, captured into color
// SHOW  | LED lit for ON_CYCLES
// GAP   | LEDs dark for OFF_CYCLES, then advance idx
// DONE  | blinker_done pulse (one cycle)
// HOLD  | wait for on_blinker to drop before re-arming
module simon_blinker #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_LEVEL  = 10,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  simon_blinker_if.slave        bus,
  output logic [3:0]            leds
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  // wide enough to compare idx+1 with len without wrapping
  localparam int IW      = ((ADDR_W > 4) ? ADDR_W : 4) + 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [3:0]       MAX_LVL  = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LOAD = 3'd2,
    SHOW = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5,
    HOLD = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [1:0]        color, color_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        len, len_nxt;
  logic [3:0]        level_clamped;
  logic              last_entry;

  assign level_clamped = (bus.level > MAX_LVL) ? MAX_LVL : bus.level;
  assign last_entry    = ((IW'(idx) + IW'(1)) == IW'(len));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      color <= '0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      color <= color_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    color_nxt = color;
    cnt_nxt   = cnt;
    len_nxt   = len;
    leds      = 4'b0000;

    case (state)
      IDLE: begin
        idx_nxt = '0;
        cnt_nxt = '0;
        if (bus.on_blinker) begin
          len_nxt   = level_clamped;
          state_nxt = (level_clamped == 4'd0) ? DONE : ADDR;
        end
      end

      ADDR: begin
        state_nxt = bus.on_blinker ? LOAD : IDLE;
      end

      LOAD: begin
        if (bus.on_blinker) begin
          color_nxt = bus.mem_data;
          cnt_nxt   = '0;
          state_nxt = SHOW;
        end else begin
          state_nxt = IDLE;
        end
      end

      SHOW: begin
        // gated by on_blinker so an abort darkens the LED immediately
        if (bus.on_blinker) begin
          leds = 4'b0001 << color;
          if (cnt == ON_LAST) begin
            cnt_nxt   = '0;
            state_nxt = GAP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      GAP: begin
        if (bus.on_blinker) begin
          if (cnt == OFF_LAST) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + 1'b1;
            state_nxt = last_entry ? DONE : ADDR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      DONE: begin
        state_nxt = HOLD;
      end

      HOLD: begin
        if (!bus.on_blinker) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // mem_addr follows idx, so clear it on every return to IDLE
    if (state != IDLE && state_nxt == IDLE) idx_nxt = '0;
  end

  assign bus.mem_addr     = idx;
  assign bus.blinker_done = (state == DONE);
  assign bus.busy         = (state != IDLE);

endmodule
